// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of fetched packets with
// valid/ready on both sides and a flush that re-issues the resolved target to fetch.
module fetch_decode_queue #(
    parameter int DEPTH  = 2,
    parameter int XLEN   = 32,
    parameter int PRED_W = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [XLEN-1:0]            fetch_pc,
    input  logic [XLEN-1:0]            fetch_pc4,
    input  logic [XLEN-1:0]            fetch_inst,
    input  logic                       fetch_token,
    input  logic [PRED_W-1:0]          fetch_pred,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [XLEN-1:0]            dec_pc,
    output logic [XLEN-1:0]            dec_pc4,
    output logic [XLEN-1:0]            dec_inst,
    output logic                       dec_token,
    output logic [PRED_W-1:0]          dec_pred,
    input  logic                       brj_valid,
    input  logic [XLEN-1:0]            brj_addr,
    output logic                       redirect_valid,
    output logic [XLEN-1:0]            redirect_addr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc4;
        logic [XLEN-1:0]   inst;
        logic              token;
        logic [PRED_W-1:0] pred;
    } pkt_t;

    pkt_t             mem [DEPTH];
    pkt_t             wr_pkt;
    pkt_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic             push, pop;

    assign fetch_ready = (count != CNT_W'(DEPTH));
    assign dec_valid   = (count != '0);

    // A flush cycle discards whatever handshakes happen to be offered alongside it.
    assign push = fetch_valid && fetch_ready && !brj_valid;
    assign pop  = dec_valid && dec_ready && !brj_valid;

    // Explicit wrap so non-power-of-two depths work.
    assign wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    assign wr_pkt = '{pc: fetch_pc, pc4: fetch_pc4, inst: fetch_inst,
                      token: fetch_token, pred: fetch_pred};

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= wr_pkt;
    end

    assign head      = mem[rd_ptr];
    assign dec_pc    = head.pc;
    assign dec_pc4   = head.pc4;
    assign dec_inst  = head.inst;
    assign dec_token = head.token;
    assign dec_pred  = head.pred;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end else if (brj_valid) begin
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            redirect_valid <= 1'b1;
            redirect_addr  <= brj_addr;
        end else begin
            redirect_valid <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr_nxt;
            if (pop)
                rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Drives a DEPTH=2 and a DEPTH=3 queue with shared stimulus and checks both
// every cycle against queue-based reference models.
module tb_fetch_decode_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        token;
        logic        pred;
    } pkt_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0, fetch_pc4 = '0, fetch_inst = '0;
    logic        fetch_token = 1'b0;
    logic [0:0]  fetch_pred = '0;
    logic        dec_ready = 1'b0;
    logic        brj_valid = 1'b0;
    logic [31:0] brj_addr = '0;

    logic        a_fr, a_dv, a_tok, a_rv;
    logic [31:0] a_pc, a_pc4, a_inst, a_ra;
    logic [0:0]  a_pred;
    logic [1:0]  a_cnt;
    logic        b_fr, b_dv, b_tok, b_rv;
    logic [31:0] b_pc, b_pc4, b_inst, b_ra;
    logic [0:0]  b_pred;
    logic [1:0]  b_cnt;

    int n_chk = 0;
    int n_err = 0;

    pkt_t        qa[$];
    pkt_t        qb[$];
    logic        m_rv = 1'b0;
    logic [31:0] m_ra = '0;
    logic [31:0] pc_seq = 32'h100;

    always #5 CLK = ~CLK;

    fetch_decode_queue #(.DEPTH(2), .XLEN(32), .PRED_W(1)) u_d2 (
        .CLK(CLK), .RST(RST),
        .fetch_valid(fetch_valid), .fetch_ready(a_fr),
        .fetch_pc(fetch_pc), .fetch_pc4(fetch_pc4), .fetch_inst(fetch_inst),
        .fetch_token(fetch_token), .fetch_pred(fetch_pred),
        .dec_valid(a_dv), .dec_ready(dec_ready),
        .dec_pc(a_pc), .dec_pc4(a_pc4), .dec_inst(a_inst),
        .dec_token(a_tok), .dec_pred(a_pred),
        .brj_valid(brj_valid), .brj_addr(brj_addr),
        .redirect_valid(a_rv), .redirect_addr(a_ra), .count(a_cnt)
    );

    fetch_decode_queue #(.DEPTH(3), .XLEN(32), .PRED_W(1)) u_d3 (
        .CLK(CLK), .RST(RST),
        .fetch_valid(fetch_valid), .fetch_ready(b_fr),
        .fetch_pc(fetch_pc), .fetch_pc4(fetch_pc4), .fetch_inst(fetch_inst),
        .fetch_token(fetch_token), .fetch_pred(fetch_pred),
        .dec_valid(b_dv), .dec_ready(dec_ready),
        .dec_pc(b_pc), .dec_pc4(b_pc4), .dec_inst(b_inst),
        .dec_token(b_tok), .dec_pred(b_pred),
        .brj_valid(brj_valid), .brj_addr(brj_addr),
        .redirect_valid(b_rv), .redirect_addr(b_ra), .count(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_side(input string n, input pkt_t q[$], input int d,
                            input logic [1:0] cnt, input logic fr, input logic dv,
                            input pkt_t head, input logic rv, input logic [31:0] ra);
        chk({n, ".count"}, 64'(cnt), 64'(q.size()));
        chk({n, ".fetch_ready"}, 64'(fr), 64'(q.size() != d));
        chk({n, ".dec_valid"}, 64'(dv), 64'(q.size() != 0));
        chk({n, ".redirect_valid"}, 64'(rv), 64'(m_rv));
        chk({n, ".redirect_addr"}, 64'(ra), 64'(m_ra));
        if (q.size() != 0) begin
            chk({n, ".dec_pc"}, 64'(head.pc), 64'(q[0].pc));
            chk({n, ".dec_pc4"}, 64'(head.pc4), 64'(q[0].pc4));
            chk({n, ".dec_inst"}, 64'(head.inst), 64'(q[0].inst));
            chk({n, ".dec_token"}, 64'(head.token), 64'(q[0].token));
            chk({n, ".dec_pred"}, 64'(head.pred), 64'(q[0].pred));
        end
    endtask

    task automatic check_all();
        chk_side("d2", qa, 2, a_cnt, a_fr, a_dv, '{a_pc, a_pc4, a_inst, a_tok, a_pred[0]}, a_rv, a_ra);
        chk_side("d3", qb, 3, b_cnt, b_fr, b_dv, '{b_pc, b_pc4, b_inst, b_tok, b_pred[0]}, b_rv, b_ra);
    endtask

    function automatic void model_reset();
        qa.delete();
        qb.delete();
        m_rv = 1'b0;
        m_ra = '0;
    endfunction

    // Reference behaviour at a rising edge, from the pre-edge model state.
    function automatic void model_edge();
        pkt_t p;
        bit   pa, pb;
        if (RST) begin
            model_reset();
        end else if (brj_valid) begin
            qa.delete();
            qb.delete();
            m_rv = 1'b1;
            m_ra = brj_addr;
        end else begin
            m_rv = 1'b0;
            p  = '{fetch_pc, fetch_pc4, fetch_inst, fetch_token, fetch_pred[0]};
            pa = fetch_valid && qa.size() < 2;
            pb = fetch_valid && qb.size() < 3;
            if (dec_ready && qa.size() > 0) void'(qa.pop_front());
            if (dec_ready && qb.size() > 0) void'(qb.pop_front());
            if (pa) qa.push_back(p);
            if (pb) qb.push_back(p);
        end
    endfunction

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc);
        fetch_valid = v;
        fetch_pc    = pc;
        fetch_pc4   = pc + 32'd4;
        fetch_inst  = $urandom;
        fetch_token = 1'($urandom_range(0, 1));
        fetch_pred  = 1'($urandom_range(0, 1));
    endtask

    task automatic async_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        chk("async_rst.count", 64'(a_cnt), 64'd0);
        chk("async_rst.dec_valid", 64'(a_dv), 64'd0);
        chk("async_rst.redirect_valid", 64'(a_rv), 64'd0);
        check_all();
        step();
        RST = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        check_all();
        step();
        RST = 1'b0;
        step();

        // Fill/drain: A, B, then a refused third push on the 2-deep queue.
        dec_ready = 1'b0;
        set_fetch(1'b1, 32'h100); step();
        set_fetch(1'b1, 32'h104); step();
        chk("fill.count_full", 64'(a_cnt), 64'd2);
        set_fetch(1'b1, 32'h108); step();
        set_fetch(1'b0, 32'h0);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Push while full with a pop: pop happens, push refused, then accepted.
        dec_ready = 1'b0;
        set_fetch(1'b1, 32'h200); step();
        set_fetch(1'b1, 32'h204); step();
        dec_ready = 1'b1;
        set_fetch(1'b1, 32'h208); step();
        chk("full_pushpop.count", 64'(a_cnt), 64'd1);
        step();
        set_fetch(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step();

        // Streaming one packet per cycle.
        dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_fetch(1'b1, 32'h300 + 32'(i * 4));
            step();
        end
        set_fetch(1'b0, 32'h0);
        step();

        // Flush with push and pop offered alongside.
        dec_ready = 1'b0;
        set_fetch(1'b1, 32'h400); step();
        set_fetch(1'b1, 32'h404); step();
        dec_ready = 1'b1;
        set_fetch(1'b1, 32'h408);
        brj_valid = 1'b1;
        brj_addr  = 32'h2000;
        step();
        chk("flush.redirect_addr", 64'(a_ra), 64'h2000);
        brj_valid = 1'b0;
        set_fetch(1'b0, 32'h0);
        step();
        chk("flush.redirect_clear", 64'(a_rv), 64'd0);

        // Back-to-back flushes: last address wins, new packet accepted after.
        brj_valid = 1'b1; brj_addr = 32'h3000; step();
        brj_addr = 32'h3100; step();
        brj_valid = 1'b0;
        set_fetch(1'b1, 32'h3100); step();
        set_fetch(1'b0, 32'h0); step();

        // Randomized traffic with stalls and occasional redirects.
        for (int i = 0; i < 400; i++) begin
            set_fetch(1'($urandom_range(0, 3) != 0), pc_seq);
            pc_seq    = pc_seq + 32'd4;
            dec_ready = ($urandom_range(0, 2) != 0);
            brj_valid = ($urandom_range(0, 19) == 0);
            brj_addr  = $urandom;
            step();
        end
        brj_valid = 1'b0;

        // Async reset with the 2-deep queue full.
        dec_ready = 1'b0;
        set_fetch(1'b1, 32'h500); step();
        set_fetch(1'b1, 32'h504); step();
        chk("pre_rst.count", 64'(a_cnt), 64'd2);
        set_fetch(1'b0, 32'h0);
        async_reset();

        // Async reset while a redirect is pending.
        brj_valid = 1'b1; brj_addr = 32'h6000; step();
        brj_valid = 1'b0;
        chk("pre_rst.redirect_valid", 64'(a_rv), 64'd1);
        async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
